// File: rtl/round_judge.sv
// Judges each tank round: after the first hit, waits a window of frame_ticks so a trading shot
// can land, then emits one registered redwin/greenwin/draw pulse and freezes play until re-armed.
module round_judge #(
   parameter int SETTLE_FRAMES = 30,
   parameter int CNT_W         = 6
) (
   input  logic clk,
   input  logic reset_n,
   input  logic screenreset,
   input  logic frame_tick,
   input  logic red_hit,
   input  logic green_hit,
   output logic redwin,
   output logic greenwin,
   output logic draw,
   output logic freeze
);

   typedef enum logic [2:0] {IDLE, PLAY, SETTLE, REPORT, WAIT_ACK, CLEAR} state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_FRAMES - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             red_dead_q, red_dead_d;
   logic             green_dead_q, green_dead_d;
   logic             redwin_q, redwin_d;
   logic             greenwin_q, greenwin_d;
   logic             draw_q, draw_d;
   logic             freeze_q, freeze_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         red_dead_q   <= 1'b0;
         green_dead_q <= 1'b0;
         redwin_q     <= 1'b0;
         greenwin_q   <= 1'b0;
         draw_q       <= 1'b0;
         freeze_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         red_dead_q   <= red_dead_d;
         green_dead_q <= green_dead_d;
         redwin_q     <= redwin_d;
         greenwin_q   <= greenwin_d;
         draw_q       <= draw_d;
         freeze_q     <= freeze_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      red_dead_d   = red_dead_q;
      green_dead_d = green_dead_q;
      case (state_q)
         IDLE: begin
            if (!screenreset) state_d = PLAY;
         end
         PLAY: begin
            if (screenreset) begin
               state_d = IDLE;
            end else if (red_hit || green_hit) begin
               state_d      = SETTLE;
               red_dead_d   = red_hit;
               green_dead_d = green_hit;
               cnt_d        = '0;
            end
         end
         SETTLE: begin
            if (screenreset) begin
               state_d = IDLE;
            end else begin
               red_dead_d   = red_dead_q | red_hit;
               green_dead_d = green_dead_q | green_hit;
               // Leaving at LAST_CNT means the counter can never pass it or wrap.
               if (frame_tick) begin
                  if (cnt_q == LAST_CNT) state_d = REPORT;
                  else                   cnt_d   = cnt_q + CNT_W'(1);
               end
            end
         end
         REPORT: begin
            state_d = (red_dead_q && green_dead_q) ? CLEAR : WAIT_ACK;
         end
         WAIT_ACK: begin
            if (screenreset) state_d = IDLE;
         end
         CLEAR: begin
            red_dead_d   = 1'b0;
            green_dead_d = 1'b0;
            if (screenreset)                  state_d = IDLE;
            else if (!red_hit && !green_hit)  state_d = PLAY;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they appear registered, in step with the state.
   always_comb begin
      greenwin_d = (state_d == REPORT) && red_dead_d && !green_dead_d;
      redwin_d   = (state_d == REPORT) && green_dead_d && !red_dead_d;
      draw_d     = (state_d == REPORT) && red_dead_d && green_dead_d;
      freeze_d   = (state_d == SETTLE) || (state_d == REPORT) ||
                   (state_d == WAIT_ACK) || (state_d == CLEAR);
   end

   assign redwin   = redwin_q;
   assign greenwin = greenwin_q;
   assign draw     = draw_q;
   assign freeze   = freeze_q;

endmodule

// File: tb/tb_round_judge.sv
// Bench for round_judge: directed round scenarios with literal expectations plus a randomized
// phase, all compared every cycle against a round-level behavioural model.
module tb_round_judge;

   localparam int SETTLE = 3;

   logic clk = 1'b0;
   logic reset_n;
   logic screenreset, frame_tick, red_hit, green_hit;
   logic redwin, greenwin, draw, freeze;

   round_judge #(.SETTLE_FRAMES(SETTLE), .CNT_W(2)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .screenreset(screenreset),
      .frame_tick (frame_tick),
      .red_hit    (red_hit),
      .green_hit  (green_hit),
      .redwin     (redwin),
      .greenwin   (greenwin),
      .draw       (draw),
      .freeze     (freeze)
   );

   always #5 clk = ~clk;

   // Round-level model: which phase of a round we are in, counted with plain integers.
   typedef struct packed {
      logic       live;      // screen is in a game
      logic       pending;   // settle window open
      logic       won;       // win shown, waiting for screen ack
      logic       clearing;  // draw shown, waiting for both tanks clear
      logic       rd, gd;
      logic       rw, gw, dr, frz;
      logic [7:0] ticks;
   } m_t;

   function automatic m_t model_step(input m_t c, input logic sr, input logic ft,
                                     input logic rh, input logic gh);
      m_t n;
      n    = c;
      n.rw = 1'b0;
      n.gw = 1'b0;
      n.dr = 1'b0;
      if (c.rw || c.gw || c.dr) begin
         if (c.dr) begin
            n.clearing = 1'b1;
            n.rd = 1'b0;
            n.gd = 1'b0;
         end else begin
            n.won = 1'b1;
         end
      end else if (!c.live) begin
         n.live = !sr;
      end else if (c.won) begin
         if (sr) begin
            n.live = 1'b0;
            n.won  = 1'b0;
         end
      end else if (c.clearing) begin
         if (sr) begin
            n.live     = 1'b0;
            n.clearing = 1'b0;
         end else if (!rh && !gh) begin
            n.clearing = 1'b0;
         end
      end else if (c.pending) begin
         if (sr) begin
            n.live    = 1'b0;
            n.pending = 1'b0;
         end else begin
            n.rd = c.rd | rh;
            n.gd = c.gd | gh;
            if (ft) n.ticks = c.ticks + 8'd1;
            if (n.ticks == 8'(SETTLE)) begin
               n.pending = 1'b0;
               n.gw = n.rd & !n.gd;
               n.rw = n.gd & !n.rd;
               n.dr = n.rd & n.gd;
            end
         end
      end else begin
         if (sr) begin
            n.live = 1'b0;
         end else if (rh || gh) begin
            n.pending = 1'b1;
            n.ticks   = 8'd0;
            n.rd      = rh;
            n.gd      = gh;
         end
      end
      n.frz = n.pending | n.won | n.clearing | n.rw | n.gw | n.dr;
      return n;
   endfunction

   m_t m;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) m <= '0;
      else          m <= model_step(m, screenreset, frame_tick, red_hit, green_hit);
   end

   int         n_tests = 0;
   int         n_fail  = 0;
   logic       lit_vld, pend_vld;
   logic [3:0] lit, pend;
   logic [3:0] act, mdl;

   // Single compare process: DUT vs model every cycle, plus literal pins on DUT and model.
   initial forever begin
      @(negedge clk);
      act = {redwin, greenwin, draw, freeze};
      mdl = {m.rw, m.gw, m.dr, m.frz};
      n_tests++;
      if (act !== mdl) begin
         n_fail++;
         $display("FAIL model_cmp t=%0t dut{rw,gw,dr,frz}=%b expected=%b", $time, act, mdl);
      end
      if (lit_vld) begin
         n_tests++;
         if (act !== lit) begin
            n_fail++;
            $display("FAIL literal_dut t=%0t dut{rw,gw,dr,frz}=%b expected=%b", $time, act, lit);
         end
         n_tests++;
         if (mdl !== lit) begin
            n_fail++;
            $display("FAIL literal_model t=%0t model{rw,gw,dr,frz}=%b expected=%b", $time, mdl, lit);
         end
      end
   end

   // Applies inputs for one cycle; exp is the output expected once those inputs are clocked in.
   task automatic drive(input logic sr, input logic ft, input logic rh, input logic gh,
                        input logic [3:0] exp);
      @(posedge clk);
      #2;
      lit         = pend;
      lit_vld     = pend_vld;
      screenreset = sr;
      frame_tick  = ft;
      red_hit     = rh;
      green_hit   = gh;
      pend        = exp;
      pend_vld    = 1'b1;
   endtask

   task automatic async_reset();
      @(posedge clk);
      #2;
      reset_n     = 1'b0;
      lit         = 4'b0000;
      lit_vld     = 1'b1;
      pend_vld    = 1'b0;
      screenreset = 1'b1;
      frame_tick  = 1'b0;
      red_hit     = 1'b0;
      green_hit   = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n     = 1'b0;
      screenreset = 1'b1;
      frame_tick  = 1'b0;
      red_hit     = 1'b0;
      green_hit   = 1'b0;
      lit         = 4'b0000;
      lit_vld     = 1'b1;
      pend        = 4'b0000;
      pend_vld    = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      reset_n = 1'b1;

      // Red hit alone -> greenwin after the third tick.
      drive(1, 0, 0, 0, 4'b0000);
      drive(0, 0, 0, 0, 4'b0000);
      drive(0, 0, 1, 0, 4'b0001);
      drive(0, 1, 0, 0, 4'b0001);
      drive(0, 1, 0, 0, 4'b0001);
      drive(0, 1, 0, 0, 4'b0101);
      drive(0, 0, 0, 0, 4'b0001);
      drive(1, 0, 0, 0, 4'b0000);
      drive(0, 0, 0, 0, 4'b0000);

      // Trading shot inside the window -> draw, then back to play once both clear.
      drive(0, 0, 0, 1, 4'b0001);
      drive(0, 1, 0, 0, 4'b0001);
      drive(0, 1, 1, 0, 4'b0001);
      drive(0, 1, 0, 0, 4'b0011);
      drive(0, 0, 0, 0, 4'b0001);
      drive(0, 0, 0, 0, 4'b0000);

      // Simultaneous first hits -> draw; CLEAR waits for hits to drop.
      drive(0, 0, 1, 1, 4'b0001);
      drive(0, 1, 0, 0, 4'b0001);
      drive(0, 1, 0, 0, 4'b0001);
      drive(0, 1, 0, 0, 4'b0011);
      drive(0, 0, 1, 0, 4'b0001);
      drive(0, 0, 1, 0, 4'b0001);
      drive(0, 0, 0, 0, 4'b0000);

      // Screen leaves the game mid-window: no pulse, ticks ignored.
      drive(0, 0, 0, 1, 4'b0001);
      drive(0, 1, 0, 0, 4'b0001);
      drive(1, 0, 0, 0, 4'b0000);
      drive(1, 1, 0, 0, 4'b0000);
      drive(1, 1, 0, 0, 4'b0000);
      drive(1, 1, 0, 0, 4'b0000);

      // Tick coinciding with the first hit is not counted.
      drive(0, 0, 0, 0, 4'b0000);
      drive(0, 1, 1, 0, 4'b0001);
      drive(0, 1, 0, 0, 4'b0001);
      drive(0, 1, 0, 0, 4'b0001);
      drive(0, 1, 0, 0, 4'b0101);

      // Win held without ack: no re-report, then a fresh round is judged.
      for (int i = 0; i < 100; i++)
         drive(0, 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 4'b0001);
      drive(1, 0, 0, 0, 4'b0000);
      drive(0, 0, 0, 0, 4'b0000);
      drive(0, 0, 0, 1, 4'b0001);
      drive(0, 1, 0, 0, 4'b0001);
      drive(0, 1, 0, 0, 4'b0001);
      drive(0, 1, 0, 0, 4'b1001);
      drive(0, 0, 0, 0, 4'b0001);
      drive(1, 0, 0, 0, 4'b0000);

      // Asynchronous reset in the middle of a window.
      drive(0, 0, 0, 0, 4'b0000);
      drive(0, 0, 1, 0, 4'b0001);
      drive(0, 1, 0, 0, 4'b0001);
      async_reset();
      drive(1, 0, 0, 0, 4'b0000);
      drive(0, 0, 1, 0, 4'b0000);
      drive(0, 0, 1, 0, 4'b0001);
      drive(1, 0, 0, 0, 4'b0000);
      drive(1, 0, 0, 0, 4'b0000);

      // Randomized traffic, model comparison only.
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #2;
         lit_vld     = 1'b0;
         pend_vld    = 1'b0;
         reset_n     = ($urandom_range(0, 299) != 0);
         screenreset = ($urandom_range(0, 15) == 0);
         frame_tick  = ($urandom_range(0, 2) == 0);
         red_hit     = ($urandom_range(0, 7) == 0);
         green_hit   = ($urandom_range(0, 7) == 0);
      end
      @(posedge clk);
      #2;
      reset_n = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
